// File: rtl/encode_pkg.sv
// Shared definitions for the packet-encoder scheduling slice: packet geometry,
// router header constants and the scheduler state encoding.
package encode_pkg;

    localparam int unsigned NUMBER_PACKET = 19;    // flits per encoded 1024-bit block
    localparam int unsigned ADDR_WIDTH    = 10;    // destination router address width
    localparam int unsigned DATA_WIDTH    = 1024;  // payload bits per requester block

    localparam int unsigned TTL_INIT      = 15;    // initial hop budget written by the encoder
    localparam int unsigned SRC_ROUTER    = 0;     // this router's own address

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GRANT     = 3'd1,
        ST_HANDOFF   = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RELEASE   = 3'd4
    } sched_state_e;

    // True while a winner owns the encoder (data-mux select must be held).
    function automatic logic sched_active(input sched_state_e s);
        return (s == ST_GRANT) || (s == ST_HANDOFF) ||
               (s == ST_WAIT_DONE) || (s == ST_RELEASE);
    endfunction

endpackage

// File: rtl/encode_scheduler_if.sv
// Handshake bundle between the scheduler, the local-port requesters and the
// encoder/data mux.
//   master : scheduler side (drives grant/select/ack/valid/address)
//   slave  : requester + encoder side
interface encode_scheduler_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned FREE_W     = 6
);
    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_dst_addr_i;
    logic [NUM_REQ-1:0]            req_ack_o;
    logic [NUM_REQ-1:0]            gnt_sel_o;
    logic                          arbiter_gnt_o;
    logic                          ctrl_encode_valid_o;
    logic                          ctrl_encode_ready_i;
    logic [ADDR_WIDTH-1:0]         router_dst_addr_send_o;
    logic                          encode_done_i;
    logic [FREE_W-1:0]             fifo_free_i;

    modport master (
        input  req_valid_i, req_dst_addr_i, ctrl_encode_ready_i, encode_done_i, fifo_free_i,
        output req_ack_o, gnt_sel_o, arbiter_gnt_o, ctrl_encode_valid_o, router_dst_addr_send_o
    );

    modport slave (
        output req_valid_i, req_dst_addr_i, ctrl_encode_ready_i, encode_done_i, fifo_free_i,
        input  req_ack_o, gnt_sel_o, arbiter_gnt_o, ctrl_encode_valid_o, router_dst_addr_send_o
    );
endinterface

// File: rtl/encode_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request searching from i_ptr+1
// with wrap-around. The pointer register lives in the caller.
//   i_req     : request vector
//   i_ptr     : index of the last winner
//   o_gnt_c   : one-hot grant
//   o_idx_c   : grant index
//   o_valid_c : any request present
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt_c,
    output logic [IDX_W-1:0]   o_idx_c,
    output logic               o_valid_c
);

    int unsigned      w_cand;
    logic [IDX_W-1:0] w_cand_idx;

    // Scan offsets 1..NUM_REQ so the last winner is checked last.
    always_comb begin
        o_gnt_c    = '0;
        o_idx_c    = '0;
        o_valid_c  = 1'b0;
        w_cand     = 0;
        w_cand_idx = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            w_cand     = (32'(i_ptr) + off) % NUM_REQ;
            w_cand_idx = IDX_W'(w_cand);
            if (!o_valid_c && i_req[w_cand_idx]) begin
                o_valid_c           = 1'b1;
                o_idx_c             = w_cand_idx;
                o_gnt_c[w_cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/encode_scheduler.sv
// Shares one packet encoder between NUM_REQ local requesters. A round-robin
// winner is picked only when the TX FIFO can take a whole packet; the winner's
// mux select is held until the encoder reports its last flit.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (master)    : requester valid/address/ack, data-mux select, encoder
//                     grant/valid/ready/address/done, FIFO free count
//   busy_o          : scheduler not idle
//   err_timeout_o   : sticky watchdog flag
//   err_clear_i     : clears err_timeout_o (wins over a same-cycle set)
// Build option ENCODE_SCHED_WDOG_EN: enables the HANDOFF/WAIT_DONE watchdog;
// without it the scheduler waits indefinitely and err_timeout_o stays 0.
module encode_scheduler #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned ADDR_WIDTH    = encode_pkg::ADDR_WIDTH,
    parameter int unsigned NUMBER_PACKET = encode_pkg::NUMBER_PACKET,
    parameter int unsigned FREE_W        = 6
`ifdef ENCODE_SCHED_WDOG_EN
    , parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    encode_scheduler_if.master   bus,
    output logic                 busy_o,
    output logic                 err_timeout_o,
    input  logic                 err_clear_i
);
    import encode_pkg::*;

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    sched_state_e          r_state, w_state_nxt;
    logic [IDX_W-1:0]      r_ptr, w_ptr_nxt;
    logic [IDX_W-1:0]      r_winner, w_winner_nxt;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [NUM_REQ-1:0]    r_gnt_sel, w_gnt_sel_nxt;
    logic [NUM_REQ-1:0]    r_ack, w_ack_nxt;
    logic                  r_arb_gnt, r_valid, r_busy, r_err;
    logic                  w_timeout;

    logic [NUM_REQ-1:0]    w_arb_gnt;
    logic [IDX_W-1:0]      w_arb_idx;
    logic                  w_arb_valid;
    logic                  w_fifo_room;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .i_req     (bus.req_valid_i),
        .i_ptr     (r_ptr),
        .o_gnt_c   (w_arb_gnt),
        .o_idx_c   (w_arb_idx),
        .o_valid_c (w_arb_valid)
    );

    assign w_fifo_room = (bus.fifo_free_i >= FREE_W'(NUMBER_PACKET));

`ifdef ENCODE_SCHED_WDOG_EN
    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDOG_W-1:0] r_wdog_cnt;
    logic              w_wdog_hit;

    assign w_wdog_hit = ((r_state == ST_HANDOFF) || (r_state == ST_WAIT_DONE)) &&
                        (r_wdog_cnt == WDOG_W'(TIMEOUT_CYCLES - 1));

    // Restarts on every state change; counts only while waiting on the encoder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_wdog_cnt <= '0;
        end else if ((r_state == ST_HANDOFF) || (r_state == ST_WAIT_DONE)) begin
            r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1);
        end
    end
`else
    logic w_wdog_hit;
    assign w_wdog_hit = 1'b0;
`endif

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_winner_nxt  = r_winner;
        w_addr_nxt    = r_addr;
        w_gnt_sel_nxt = '0;
        w_ack_nxt     = '0;
        w_timeout     = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_arb_valid && w_fifo_room) begin
                    w_winner_nxt  = w_arb_idx;
                    w_addr_nxt    = bus.req_dst_addr_i[w_arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    w_gnt_sel_nxt = w_arb_gnt;
                    w_state_nxt   = ST_GRANT;
                end
            end
            ST_GRANT:     w_state_nxt = ST_HANDOFF;
            ST_HANDOFF:   if (bus.ctrl_encode_ready_i) w_state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: if (bus.encode_done_i)       w_state_nxt = ST_RELEASE;
            ST_RELEASE: begin
                w_ptr_nxt   = r_winner;
                w_state_nxt = ST_IDLE;
            end
            default:      w_state_nxt = ST_IDLE;
        endcase

        // A handshake landing on the final watchdog cycle still completes normally.
        if (w_wdog_hit && (w_state_nxt == r_state)) begin
            w_timeout   = 1'b1;
            w_ptr_nxt   = r_winner;
            w_state_nxt = ST_IDLE;
        end

        if (sched_active(w_state_nxt) && (r_state != ST_IDLE)) begin
            w_gnt_sel_nxt = r_gnt_sel;
        end
        if (w_state_nxt == ST_RELEASE) begin
            w_ack_nxt = r_gnt_sel;
        end
    end

    // State, latched winner data and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= IDX_W'(NUM_REQ - 1);
            r_winner  <= '0;
            r_addr    <= '0;
            r_gnt_sel <= '0;
            r_ack     <= '0;
            r_arb_gnt <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_winner  <= w_winner_nxt;
            r_addr    <= w_addr_nxt;
            r_gnt_sel <= w_gnt_sel_nxt;
            r_ack     <= w_ack_nxt;
            r_arb_gnt <= (w_state_nxt == ST_GRANT);
            r_valid   <= (w_state_nxt == ST_HANDOFF);
            r_busy    <= (w_state_nxt != ST_IDLE);
            if (err_clear_i) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.req_ack_o              = r_ack;
    assign bus.gnt_sel_o              = r_gnt_sel;
    assign bus.arbiter_gnt_o          = r_arb_gnt;
    assign bus.ctrl_encode_valid_o    = r_valid;
    assign bus.router_dst_addr_send_o = r_addr;
    assign busy_o                     = r_busy;
    assign err_timeout_o              = r_err;

endmodule

// File: tb/tb_encode_scheduler.sv
// Directed bench for encode_scheduler: reset, single request, fairness,
// FIFO backpressure, ready stall, async reset mid-transaction and (when
// ENCODE_SCHED_WDOG_EN is defined) the watchdog.
module tb_encode_scheduler;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 10;
    localparam int unsigned FW = 6;

    logic clk;
    logic rst_n;
    logic busy;
    logic err_timeout;
    logic err_clear;

    int checks;
    int failures;

    encode_scheduler_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .FREE_W(FW)) bus ();

    encode_scheduler #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .NUMBER_PACKET(19), .FREE_W(FW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .busy_o        (busy),
        .err_timeout_o (err_timeout),
        .err_clear_i   (err_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute bound on the run.
    initial begin
        #2ms;
        $display("FAIL run_timeout observed=still_running expected=finished");
        $fatal(1, "run did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full transaction starting in IDLE with the winner's request present.
    task automatic do_txn(input logic [NR-1:0] exp_sel, input logic [AW-1:0] exp_addr,
                          input int ready_wait, input bit inject_done, input bit clear_on_ack);
        tick();
        chk("grant_pulse", 32'(bus.arbiter_gnt_o), 32'd1);
        chk("grant_sel",   32'(bus.gnt_sel_o), 32'(exp_sel));
        chk("grant_valid", 32'(bus.ctrl_encode_valid_o), 32'd0);
        chk("grant_busy",  32'(busy), 32'd1);
        tick();
        chk("handoff_valid", 32'(bus.ctrl_encode_valid_o), 32'd1);
        chk("handoff_addr",  32'(bus.router_dst_addr_send_o), 32'(exp_addr));
        chk("handoff_gnt",   32'(bus.arbiter_gnt_o), 32'd0);
        chk("handoff_sel",   32'(bus.gnt_sel_o), 32'(exp_sel));
        for (int i = 0; i < ready_wait; i++) begin
            if (inject_done && i == 0) bus.encode_done_i = 1'b1;
            tick();
            bus.encode_done_i = 1'b0;
            chk("stall_valid", 32'(bus.ctrl_encode_valid_o), 32'd1);
            chk("stall_addr",  32'(bus.router_dst_addr_send_o), 32'(exp_addr));
            chk("stall_sel",   32'(bus.gnt_sel_o), 32'(exp_sel));
        end
        bus.ctrl_encode_ready_i = 1'b1;
        tick();
        bus.ctrl_encode_ready_i = 1'b0;
        chk("wait_valid", 32'(bus.ctrl_encode_valid_o), 32'd0);
        chk("wait_sel",   32'(bus.gnt_sel_o), 32'(exp_sel));
        chk("wait_ack",   32'(bus.req_ack_o), 32'd0);
        bus.encode_done_i = 1'b1;
        tick();
        bus.encode_done_i = 1'b0;
        chk("release_ack", 32'(bus.req_ack_o), 32'(exp_sel));
        chk("release_sel", 32'(bus.gnt_sel_o), 32'(exp_sel));
        if (clear_on_ack) bus.req_valid_i = bus.req_valid_i & ~exp_sel;
        tick();
        chk("idle_ack",  32'(bus.req_ack_o), 32'd0);
        chk("idle_sel",  32'(bus.gnt_sel_o), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        err_clear = 1'b0;
        bus.req_valid_i         = '0;
        bus.req_dst_addr_i      = {10'h3c3, 10'h2b2, 10'h1a1, 10'h155};
        bus.ctrl_encode_ready_i = 1'b0;
        bus.encode_done_i       = 1'b0;
        bus.fifo_free_i         = 6'd32;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_gnt",   32'(bus.arbiter_gnt_o), 32'd0);
        chk("rst_sel",   32'(bus.gnt_sel_o), 32'd0);
        chk("rst_ack",   32'(bus.req_ack_o), 32'd0);
        chk("rst_valid", 32'(bus.ctrl_encode_valid_o), 32'd0);
        chk("rst_addr",  32'(bus.router_dst_addr_send_o), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_err",   32'(err_timeout), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_no_req", 32'(busy), 32'd0);

        // Fairness: all requests held, order 0,1,2,3,0
        bus.req_valid_i = 4'b1111;
        do_txn(4'b0001, 10'h155, 0, 1'b0, 1'b0);
        do_txn(4'b0010, 10'h1a1, 0, 1'b0, 1'b0);
        do_txn(4'b0100, 10'h2b2, 0, 1'b0, 1'b0);
        do_txn(4'b1000, 10'h3c3, 0, 1'b0, 1'b0);
        do_txn(4'b0001, 10'h155, 0, 1'b0, 1'b0);
        bus.req_valid_i = '0;

        // Single request, ready after 3 valid cycles, requester drops on ack
        bus.req_valid_i = 4'b0001;
        do_txn(4'b0001, 10'h155, 2, 1'b0, 1'b1);
        chk("single_req_cleared", 32'(bus.req_valid_i), 32'd0);

        // Backpressure: 18 free entries blocks, 19 grants next cycle
        bus.fifo_free_i = 6'd18;
        bus.req_valid_i = 4'b0010;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("bp_no_grant", 32'({bus.arbiter_gnt_o, busy}), 32'd0);
        end
        bus.fifo_free_i = 6'd19;
        do_txn(4'b0010, 10'h1a1, 0, 1'b0, 1'b1);
        bus.fifo_free_i = 6'd32;

        // Ready stall of 10 cycles with a stray encode_done_i in HANDOFF
        bus.req_valid_i = 4'b0100;
        do_txn(4'b0100, 10'h2b2, 10, 1'b1, 1'b1);

        // Async reset during WAIT_DONE
        bus.req_valid_i = 4'b1000;
        tick();
        chk("pre_rst_sel", 32'(bus.gnt_sel_o), 32'b1000);
        tick();
        bus.ctrl_encode_ready_i = 1'b1;
        tick();
        bus.ctrl_encode_ready_i = 1'b0;
        chk("pre_rst_busy",  32'(busy), 32'd1);
        chk("pre_rst_valid", 32'(bus.ctrl_encode_valid_o), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_sel",  32'(bus.gnt_sel_o), 32'd0);
        chk("async_rst_ack",  32'(bus.req_ack_o), 32'd0);
        chk("async_rst_addr", 32'(bus.router_dst_addr_send_o), 32'd0);
        bus.req_valid_i = 4'b1111;
        @(negedge clk);
        chk("in_rst_ack", 32'(bus.req_ack_o), 32'd0);
        rst_n = 1'b1;
        do_txn(4'b0001, 10'h155, 0, 1'b0, 1'b0);

`ifdef ENCODE_SCHED_WDOG_EN
        // Watchdog: no done for 64 cycles in WAIT_DONE
        tick();
        chk("wd_sel", 32'(bus.gnt_sel_o), 32'b0010);
        tick();
        bus.ctrl_encode_ready_i = 1'b1;
        tick();
        bus.ctrl_encode_ready_i = 1'b0;
        for (int i = 0; i < 63; i++) begin
            tick();
            chk("wd_waiting", 32'({busy, err_timeout, bus.req_ack_o}), 32'h20);
        end
        tick();
        chk("wd_err",  32'(err_timeout), 32'd1);
        chk("wd_busy", 32'(busy), 32'd0);
        chk("wd_ack",  32'(bus.req_ack_o), 32'd0);
        do_txn(4'b0100, 10'h2b2, 0, 1'b0, 1'b0);
        chk("wd_sticky", 32'(err_timeout), 32'd1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("wd_cleared", 32'(err_timeout), 32'd0);
`else
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("no_wdog_err", 32'(err_timeout), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
